acc_drain_quant: RTL and testbench

- Post-processing drain stage directly downstream of the 8-entry partial-sum accumulator.
- On a start pulse it reads all accumulator entries in order through the accumulator's registered read port.
- Each entry is rounded, right-shifted, optionally ReLU'd, and saturated to SIZE bits.
- Results stream to the unified-buffer writer over a valid/ready interface.

---
 rtl/acc_drain_quant.sv | 208 ++++++++++++++++++++
 tb/tb_acc_drain_quant.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/acc_drain_quant.sv
// Drain stage for the 8-entry partial-sum accumulator.
// Reads every entry in ascending order through the accumulator's registered
// read port, rounds / shifts / optionally ReLUs / saturates each value to
// SIZE bits, and streams the results over a valid/ready interface through a
// 2-entry skid FIFO.
module acc_drain_quant #(
    parameter int SIZE              = 8,
    parameter int PARTIAL_SUM_WIDTH = 2 * SIZE + $clog2(SIZE),
    parameter int DEPTH             = 8,
    parameter int ADDR_W            = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [4:0]                   shift_amt,
    input  logic                         relu_en,
    output logic                         Acc_Rd_en,
    output logic [ADDR_W-1:0]            Acc_Rd_Addr,
    input  logic [PARTIAL_SUM_WIDTH-1:0] Acc_Rd_Data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [SIZE-1:0]              out_data,
    output logic [ADDR_W-1:0]            out_addr,
    output logic                         busy,
    output logic                         done
);

    // One guard bit so the rounding add cannot overflow for in-range shifts.
    localparam int XW = PARTIAL_SUM_WIDTH + 1;

    localparam logic signed [XW-1:0] UMAX = XW'((1 << SIZE) - 1);
    localparam logic signed [XW-1:0] SMAX = XW'((1 << (SIZE - 1)) - 1);
    localparam logic signed [XW-1:0] SMIN = XW'(-(1 << (SIZE - 1)));

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Round-half-up arithmetic shift, then ReLU/unsigned or signed saturate.
    // The rounding constant is formed at XW bits, so shifts beyond the word
    // simply add nothing and the shift collapses the value to 0 or -1.
    function automatic logic [SIZE-1:0] quantize(
        input logic [PARTIAL_SUM_WIDTH-1:0] x,
        input logic [4:0]                   s,
        input logic                         relu
    );
        logic signed [XW-1:0] xe;
        logic signed [XW-1:0] rnd;
        logic signed [XW-1:0] r;
        xe  = {x[PARTIAL_SUM_WIDTH-1], x};
        rnd = {{(XW - 1){1'b0}}, 1'b1} << (s - 5'd1);
        if (s == 5'd0) begin
            r = xe;
        end else begin
            r = (xe + rnd) >>> s;
        end
        if (relu) begin
            if (r[XW-1]) begin
                quantize = {SIZE{1'b0}};
            end else if (r > UMAX) begin
                quantize = {SIZE{1'b1}};
            end else begin
                quantize = r[SIZE-1:0];
            end
        end else begin
            if (r > SMAX) begin
                quantize = SMAX[SIZE-1:0];
            end else if (r < SMIN) begin
                quantize = SMIN[SIZE-1:0];
            end else begin
                quantize = r[SIZE-1:0];
            end
        end
    endfunction

    state_t              state_q;
    logic [ADDR_W-1:0]   rd_ptr_q;
    logic [4:0]          shift_q;
    logic                relu_q;
    logic                busy_q;
    logic                done_q;

    logic                inflight_q;
    logic [ADDR_W-1:0]   cap_addr_q;
    logic [SIZE-1:0]     fifo_data_q [2];
    logic [ADDR_W-1:0]   fifo_addr_q [2];
    logic                fifo_wr_q;
    logic                fifo_rd_q;
    logic [1:0]          fifo_cnt_q;

    logic                issue_s;
    logic                push_s;
    logic                pop_s;
    logic [2:0]          occ_s;
    logic [2:0]          lim_s;
    logic [SIZE-1:0]     quant_s;

    // Read issue: a slot freed by this cycle's pop may be reused at once,
    // which is what sustains one result per cycle with a 2-entry FIFO.
    always_comb begin
        occ_s   = 3'(fifo_cnt_q) + 3'(inflight_q);
        lim_s   = 3'd2 + 3'(pop_s);
        issue_s = 1'b0;
        if (state_q == S_READ) begin
            issue_s = (occ_s < lim_s);
        end else begin
            issue_s = 1'b0;
        end
    end

    assign push_s      = inflight_q;
    assign out_valid   = (fifo_cnt_q != 2'd0);
    assign pop_s       = out_valid & out_ready;
    assign quant_s     = quantize(Acc_Rd_Data, shift_q, relu_q);
    assign Acc_Rd_en   = issue_s;
    assign Acc_Rd_Addr = rd_ptr_q;
    assign out_data    = fifo_data_q[fifo_rd_q];
    assign out_addr    = fifo_addr_q[fifo_rd_q];
    assign busy        = busy_q;
    assign done        = done_q;

    // Drain sequencer: latches the quantizer settings, walks the read pointer
    // and produces busy and the single-cycle done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            rd_ptr_q <= {ADDR_W{1'b0}};
            shift_q  <= 5'd0;
            relu_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        shift_q  <= shift_amt;
                        relu_q   <= relu_en;
                        rd_ptr_q <= {ADDR_W{1'b0}};
                        busy_q   <= 1'b1;
                        state_q  <= S_READ;
                    end
                end
                S_READ: begin
                    if (issue_s) begin
                        if (rd_ptr_q == ADDR_W'(DEPTH - 1)) begin
                            state_q <= S_FLUSH;
                        end else begin
                            rd_ptr_q <= rd_ptr_q + {{(ADDR_W - 1){1'b0}}, 1'b1};
                        end
                    end
                end
                S_FLUSH: begin
                    if (!inflight_q && (fifo_cnt_q == 2'd0)) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    rd_ptr_q <= {ADDR_W{1'b0}};
                    state_q  <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Capture of landing read data and the 2-entry result FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q     <= 1'b0;
            cap_addr_q     <= {ADDR_W{1'b0}};
            fifo_data_q[0] <= {SIZE{1'b0}};
            fifo_data_q[1] <= {SIZE{1'b0}};
            fifo_addr_q[0] <= {ADDR_W{1'b0}};
            fifo_addr_q[1] <= {ADDR_W{1'b0}};
            fifo_wr_q      <= 1'b0;
            fifo_rd_q      <= 1'b0;
            fifo_cnt_q     <= 2'd0;
        end else begin
            inflight_q <= issue_s;
            if (issue_s) begin
                cap_addr_q <= rd_ptr_q;
            end
            if (push_s) begin
                fifo_data_q[fifo_wr_q] <= quant_s;
                fifo_addr_q[fifo_wr_q] <= cap_addr_q;
                fifo_wr_q              <= ~fifo_wr_q;
            end
            if (pop_s) begin
                fifo_rd_q <= ~fifo_rd_q;
            end
            case ({push_s, pop_s})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_drain_quant.sv
// Directed testbench for acc_drain_quant with a registered-read accumulator model.
module tb_acc_drain_quant;

    localparam int SIZE  = 8;
    localparam int PSW   = 19;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic            clk       = 1'b0;
    logic            rst_n     = 1'b0;
    logic            start     = 1'b0;
    logic [4:0]      shift_amt = 5'd0;
    logic            relu_en   = 1'b0;
    logic            out_ready = 1'b0;
    logic            Acc_Rd_en;
    logic [AW-1:0]   Acc_Rd_Addr;
    logic [PSW-1:0]  Acc_Rd_Data;
    logic            out_valid;
    logic [SIZE-1:0] out_data;
    logic [AW-1:0]   out_addr;
    logic            busy;
    logic            done;

    logic [PSW-1:0]  acc_mem  [DEPTH];
    int              vals     [DEPTH];
    logic [SIZE-1:0] exp_data [DEPTH];

    int checks   = 0;
    int failures = 0;

    acc_drain_quant dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .shift_amt   (shift_amt),
        .relu_en     (relu_en),
        .Acc_Rd_en   (Acc_Rd_en),
        .Acc_Rd_Addr (Acc_Rd_Addr),
        .Acc_Rd_Data (Acc_Rd_Data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_addr    (out_addr),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Accumulator read port: data valid one cycle after the enable.
    always_ff @(posedge clk) begin
        if (Acc_Rd_en) Acc_Rd_Data <= acc_mem[Acc_Rd_Addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load_mem();
        for (int i = 0; i < DEPTH; i++) acc_mem[i] = PSW'(vals[i]);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_en"},  32'(Acc_Rd_en),   32'd0);
        check({tag, "_rd_addr"}, 32'(Acc_Rd_Addr), 32'd0);
        check({tag, "_valid"},  32'(out_valid),   32'd0);
        check({tag, "_data"},   32'(out_data),    32'd0);
        check({tag, "_addr"},   32'(out_addr),    32'd0);
        check({tag, "_busy"},   32'(busy),        32'd0);
        check({tag, "_done"},   32'(done),        32'd0);
    endtask

    // mode 0: out_ready held high; mode 1: out_ready 1,0,0,1 repeating.
    task automatic drain(input string tag, input int mode, input int restart_at, input int abort_after);
        int n_rd = 0;
        int n_hs = 0;
        int n_done = 0;
        int first_rd = -1;
        int first_valid = -1;
        int last_hs = -1;
        int done_cyc = -1;
        logic stalled = 1'b0;
        logic [SIZE-1:0] held_d = '0;
        logic [AW-1:0] held_a = '0;
        bit aborted = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            start     = (c == 0) || (c == restart_at);
            out_ready = (mode == 0) ? 1'b1 : ((c % 4 == 0) || (c % 4 == 3));
            if (c == 1) begin
                shift_amt = ~shift_amt;
                relu_en   = ~relu_en;
            end
            #1;
            if (mode == 0 && c == 0)  check({tag, "_busy_c0"}, 32'(busy), 32'd0);
            if (mode == 0 && c == 1)  check({tag, "_busy_c1"}, 32'(busy), 32'd1);
            if (mode == 0 && c == 11) check({tag, "_busy_c11"}, 32'(busy), 32'd1);
            if (Acc_Rd_en) begin
                check({tag, "_rd_addr"}, 32'(Acc_Rd_Addr), 32'(n_rd));
                if (first_rd < 0) first_rd = c;
                n_rd++;
            end
            if (stalled) begin
                check({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
                check({tag, "_stall_data"},  32'(out_data),  32'(held_d));
                check({tag, "_stall_addr"},  32'(out_addr),  32'(held_a));
            end
            if (out_valid && first_valid < 0) first_valid = c;
            if (out_valid && out_ready) begin
                check({tag, "_data"}, 32'(out_data), 32'(exp_data[n_hs % DEPTH]));
                check({tag, "_addr"}, 32'(out_addr), 32'(n_hs % DEPTH));
                n_hs++;
                last_hs = c;
            end
            stalled = out_valid && !out_ready;
            held_d  = out_data;
            held_a  = out_addr;
            check({tag, "_ahead"}, 32'((n_rd - n_hs) <= 2), 32'd1);
            if (done_cyc >= 0) begin
                check({tag, "_idle_after_done"}, 32'(busy | Acc_Rd_en), 32'd0);
            end
            if (done) begin
                n_done++;
                done_cyc = c;
                check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
            end
            if (abort_after > 0 && n_hs == abort_after) begin
                #2 rst_n = 1'b0;
                #1;
                check_reset_outputs({tag, "_abort"});
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    start = 1'b0;
                    #1;
                    if (done) n_done++;
                end
                rst_n = 1'b1;
                for (int k = 0; k < 6; k++) begin
                    @(negedge clk);
                    #1;
                    if (done) n_done++;
                end
                check({tag, "_abort_no_done"}, 32'(n_done), 32'd0);
                check({tag, "_abort_idle"}, 32'(busy | out_valid | Acc_Rd_en), 32'd0);
                aborted = 1'b1;
                break;
            end
            if (done_cyc >= 0 && c >= done_cyc + 2) break;
        end
        start = 1'b0;
        if (!aborted) begin
            check({tag, "_n_reads"}, 32'(n_rd), 32'(DEPTH));
            check({tag, "_n_hs"},    32'(n_hs), 32'(DEPTH));
            check({tag, "_n_done"},  32'(n_done), 32'd1);
            if (mode == 0) begin
                check({tag, "_lat_rd"},    32'(first_rd),    32'd1);
                check({tag, "_lat_valid"}, 32'(first_valid), 32'd3);
                check({tag, "_lat_last"},  32'(last_hs),     32'd10);
                check({tag, "_lat_done"},  32'(done_cyc),    32'd12);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // shift=4, ReLU
        vals = '{100, -50, 5000, 0, 15, 16, 7, 8};
        exp_data = '{8'd6, 8'd0, 8'd255, 8'd0, 8'd1, 8'd1, 8'd0, 8'd1};
        load_mem();
        shift_amt = 5'd4; relu_en = 1'b1;
        drain("relu_s4", 0, -1, 0);

        // shift=0, signed saturate
        vals = '{-50, 127, 128, -128, -129, -3000, 0, 1};
        exp_data = '{8'hCE, 8'h7F, 8'h7F, 8'h80, 8'h80, 8'h80, 8'h00, 8'h01};
        load_mem();
        shift_amt = 5'd0; relu_en = 1'b0;
        drain("sgn_s0", 0, -1, 0);

        // shift=2, signed, start re-pulsed in the DONE cycle
        vals = '{-3000, -6, 5, 6, 1000, -2, 2, 0};
        exp_data = '{8'h80, 8'hFF, 8'h01, 8'h02, 8'h7F, 8'h00, 8'h01, 8'h00};
        load_mem();
        shift_amt = 5'd2; relu_en = 1'b0;
        drain("sgn_s2", 0, 12, 0);

        // Back-pressure 1,0,0,1
        vals = '{100, -50, 5000, 0, 15, 16, 7, 8};
        exp_data = '{8'd6, 8'd0, 8'd255, 8'd0, 8'd1, 8'd1, 8'd0, 8'd1};
        load_mem();
        shift_amt = 5'd4; relu_en = 1'b1;
        drain("bp", 1, -1, 0);

        // Re-start while busy, then reset after the third handshake
        shift_amt = 5'd4; relu_en = 1'b1;
        drain("abort", 0, 2, 3);
        shift_amt = 5'd4; relu_en = 1'b1;
        drain("after_abort", 0, -1, 0);

        // shift=31, ReLU
        vals = '{262143, -1, 5, -262144, 0, 1, -7, 100};
        exp_data = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        load_mem();
        shift_amt = 5'd31; relu_en = 1'b1;
        drain("relu_s31", 0, -1, 0);

        // shift=31, signed
        vals = '{-1, 5, 262143, -262144, 0, 1, -7, 100};
        exp_data = '{8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00};
        load_mem();
        shift_amt = 5'd31; relu_en = 1'b0;
        drain("sgn_s31", 0, -1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
